// File: rtl/controller_sequencer_if.sv
// Control bus between the ring-counter sequencer and the datapath it steers.
// The sequencer (master) reads the IR opcode and drives every control line.
interface controller_sequencer_if;
    logic [3:0] opcode;
    logic       cp;
    logic       ep;
    logic       lm_n;
    logic       ce_n;
    logic       li_n;
    logic       ei_n;
    logic       la_n;
    logic       ea;
    logic       su;
    logic       eu;
    logic       lb_n;
    logic       lo_n;
    logic       halt;
    logic [5:0] t_state;

    modport master (
        input  opcode,
        output cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n,
        output halt, t_state
    );

    modport slave (
        output opcode,
        input  cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n,
        input  halt, t_state
    );
endinterface

// File: rtl/controller_sequencer.sv
// Six-state ring sequencer for a fetch/execute machine; decodes opcode into
// the datapath control word.
//
// state  | meaning
// T1     | PC onto bus, load MAR
// T2     | increment PC
// T3     | RAM onto bus, load IR
// T4..T6 | execute, opcode dependent
// HALTED | all-zero ring; idle word, held until reset
module controller_sequencer (
    input  logic                          clk,
    input  logic                          reset,
    controller_sequencer_if.master        seq
);
    localparam logic [5:0] T1     = 6'b000001;
    localparam logic [5:0] T2     = 6'b000010;
    localparam logic [5:0] T3     = 6'b000100;
    localparam logic [5:0] T4     = 6'b001000;
    localparam logic [5:0] T5     = 6'b010000;
    localparam logic [5:0] T6     = 6'b100000;
    localparam logic [5:0] HALTED = 6'b000000;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [5:0] state_q;
    logic [5:0] state_d;

    logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    // Any non-one-hot, non-halted value is treated as corruption and restarts the ring.
    always_comb begin
        state_d = T1;
        case (state_q)
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = T4;
            T4:      state_d = (seq.opcode == OP_HLT) ? HALTED : T5;
            T5:      state_d = T6;
            T6:      state_d = T1;
            HALTED:  state_d = HALTED;
            default: state_d = T1;
        endcase
    end

    always_comb begin
        cp   = 1'b0;
        ep   = 1'b0;
        lm_n = 1'b1;
        ce_n = 1'b1;
        li_n = 1'b1;
        ei_n = 1'b1;
        la_n = 1'b1;
        ea   = 1'b0;
        su   = 1'b0;
        eu   = 1'b0;
        lb_n = 1'b1;
        lo_n = 1'b1;
        case (state_q)
            T1: begin
                ep   = 1'b1;
                lm_n = 1'b0;
            end
            T2: cp = 1'b1;
            T3: begin
                ce_n = 1'b0;
                li_n = 1'b0;
            end
            T4: begin
                case (seq.opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ei_n = 1'b0;
                        lm_n = 1'b0;
                    end
                    OP_OUT: begin
                        ea   = 1'b1;
                        lo_n = 1'b0;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (seq.opcode)
                    OP_LDA: begin
                        ce_n = 1'b0;
                        la_n = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        ce_n = 1'b0;
                        lb_n = 1'b0;
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (seq.opcode == OP_ADD || seq.opcode == OP_SUB) begin
                    la_n = 1'b0;
                    eu   = 1'b1;
                    su   = (seq.opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    assign seq.cp      = cp;
    assign seq.ep      = ep;
    assign seq.lm_n    = lm_n;
    assign seq.ce_n    = ce_n;
    assign seq.li_n    = li_n;
    assign seq.ei_n    = ei_n;
    assign seq.la_n    = la_n;
    assign seq.ea      = ea;
    assign seq.su      = su;
    assign seq.eu      = eu;
    assign seq.lb_n    = lb_n;
    assign seq.lo_n    = lo_n;
    assign seq.halt    = (state_q == HALTED);
    assign seq.t_state = state_q;
endmodule
